// File: rtl/morse_symbol_capture.sv
// Morse key timing stage: turns press and release durations, counted in 100 ms ticks,
// into dot/dash code words and emits one committed letter per release gap.
module morse_symbol_capture #(
  parameter int DASH_TICKS  = 3,
  parameter int GAP_TICKS   = 5,
  parameter int MAX_SYMBOLS = 5,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   HundredmsTimeOut,
  input  logic                   key,
  output logic [MAX_SYMBOLS-1:0] code,
  output logic [2:0]             code_len,
  output logic                   letter_valid,
  output logic                   overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE, COMMIT} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       press_cnt_q, gap_cnt_q;
  logic [CNT_W-1:0]       press_d, gap_d;
  logic [MAX_SYMBOLS-1:0] buf_q;
  logic [2:0]             buf_len_q;
  logic                   is_dash;

  // A tick landing in the release cycle still counts toward the press length.
  always_comb begin
    press_d = press_cnt_q;
    if (HundredmsTimeOut && (press_cnt_q != CNT_W'(DASH_TICKS)))
      press_d = press_cnt_q + CNT_W'(1);
    gap_d   = gap_cnt_q + CNT_W'(HundredmsTimeOut);
    is_dash = (press_d >= CNT_W'(DASH_TICKS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      press_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      buf_q        <= '0;
      buf_len_q    <= '0;
      code         <= '0;
      code_len     <= '0;
      letter_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      overflow     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key) begin
            state_q     <= PRESS;
            press_cnt_q <= '0;
            busy        <= 1'b1;
          end
        end
        PRESS: begin
          if (!key) begin
            if (buf_len_q < 3'(MAX_SYMBOLS)) begin
              buf_q[buf_len_q] <= is_dash;
              buf_len_q        <= buf_len_q + 3'd1;
              gap_cnt_q        <= '0;
              state_q          <= RELEASE;
            end else begin
              // Too many symbols: drop the whole letter rather than commit a truncated one.
              overflow  <= 1'b1;
              buf_q     <= '0;
              buf_len_q <= '0;
              state_q   <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            press_cnt_q <= press_d;
          end
        end
        RELEASE: begin
          if (key) begin
            state_q     <= PRESS;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
          end else if (gap_d == CNT_W'(GAP_TICKS)) begin
            state_q <= COMMIT;
            busy    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_d;
          end
        end
        COMMIT: begin
          code         <= buf_q;
          code_len     <= buf_len_q;
          letter_valid <= 1'b1;
          buf_q        <= '0;
          buf_len_q    <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Directed bench: stimulus pushes expected letters/overflows into a scoreboard,
// a negedge monitor pops and compares each letter_valid / overflow pulse.
module tb_morse_symbol_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       key = 1'b0;
  logic [4:0] code;
  logic [2:0] code_len;
  logic       letter_valid, overflow, busy;

  typedef struct {
    bit         ovf;
    logic [4:0] code;
    logic [2:0] len;
  } ev_t;

  ev_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  morse_symbol_capture dut (
    .clk(clk), .rst(rst), .HundredmsTimeOut(tick), .key(key),
    .code(code), .code_len(code_len), .letter_valid(letter_valid),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (letter_valid || overflow)) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got lv=%0b ovf=%0b expected none", letter_valid, overflow);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("pulse_kind_ovf", {31'd0, overflow}, {31'd0, e.ovf});
        chk("pulse_kind_lv", {31'd0, letter_valid}, {31'd0, !e.ovf});
        if (!e.ovf) begin
          chk("letter_code", {27'd0, code}, {27'd0, e.code});
          chk("letter_len", {29'd0, code_len}, {29'd0, e.len});
        end
      end
    end
  end

  task automatic cycle(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // One tick every 4 clocks.
  task automatic ticks(input int n);
    repeat (n) begin
      repeat (3) cycle(1'b0);
      cycle(1'b1);
    end
  endtask

  task automatic press(input int n);
    key = 1'b1;
    cycle(1'b0);
    ticks(n);
  endtask

  task automatic release_key(input int n);
    key = 1'b0;
    ticks(n);
  endtask

  task automatic expect_letter(input logic [4:0] c, input logic [2:0] l);
    ev_t e;
    e.ovf = 1'b0; e.code = c; e.len = l;
    sb.push_back(e);
  endtask

  task automatic expect_ovf();
    ev_t e;
    e.ovf = 1'b1; e.code = '0; e.len = '0;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) cycle(1'b0);
    chk("rst_code", {27'd0, code}, 32'd0);
    chk("rst_len", {29'd0, code_len}, 32'd0);
    chk("rst_lv", {31'd0, letter_valid}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Idle with ticks running: nothing happens.
    ticks(20);
    chk("idle_code", {27'd0, code}, 32'd0);
    chk("idle_len", {29'd0, code_len}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Letter A: dot, dash.
    expect_letter(5'b00010, 3'd2);
    press(1);
    chk("busy_press", {31'd0, busy}, 32'd1);
    release_key(1);
    chk("busy_release", {31'd0, busy}, 32'd1);
    press(4);
    release_key(6);
    chk("A_busy_after", {31'd0, busy}, 32'd0);
    chk("A_code_hold", {27'd0, code}, 32'd2);
    chk("A_len_hold", {29'd0, code_len}, 32'd2);

    // Dash threshold: 2 ticks is a dot, 3 ticks a dash.
    expect_letter(5'b00000, 3'd1);
    press(2);
    release_key(5);
    expect_letter(5'b00001, 3'd1);
    press(3);
    release_key(5);

    // Gap of 4 ticks keeps the letter open.
    expect_letter(5'b00010, 3'd2);
    press(1);
    release_key(4);
    press(3);
    release_key(5);

    // Key rising with the gap-completing tick continues the letter.
    expect_letter(5'b00001, 3'd2);
    press(3);
    release_key(4);
    repeat (3) cycle(1'b0);
    key = 1'b1;
    cycle(1'b1);
    chk("prio_busy", {31'd0, busy}, 32'd1);
    ticks(1);
    release_key(5);

    // Six dots: overflow on the sixth release, previous letter untouched.
    expect_ovf();
    for (int i = 0; i < 6; i++) begin
      press(1);
      release_key(1);
    end
    chk("ovf_busy", {31'd0, busy}, 32'd0);
    chk("ovf_code_kept", {27'd0, code}, 32'd1);
    chk("ovf_len_kept", {29'd0, code_len}, 32'd2);
    expect_letter(5'b00001, 3'd1);
    press(3);
    release_key(5);

    // Reset in the middle of a three-dash letter.
    press(3);
    release_key(1);
    press(3);
    release_key(1);
    press(3);
    key = 1'b0;
    repeat (2) cycle(1'b0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    chk("midrst_code", {27'd0, code}, 32'd0);
    chk("midrst_len", {29'd0, code_len}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_lv", {31'd0, letter_valid}, 32'd0);
    expect_letter(5'b00000, 3'd1);
    press(1);
    release_key(5);

    repeat (8) cycle(1'b0);
    chk("pending_events", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_symbol_capture.md
Name: morse_symbol_capture

Overview:
- Sits directly downstream of the 100 ms tick stage in the Morse game datapath.
- Times key presses and releases in units of `HundredmsTimeOut` pulses and classifies each press as dot or dash.
- Accumulates up to MAX_SYMBOLS symbols into a code word and commits the letter after a release gap.
- Feeds the letter-compare/game-score logic with a one-cycle `letter_valid` pulse plus the code and its length.

Parameters:
- DASH_TICKS, 3, press lasting >= this many ticks is a dash, otherwise a dot.
- GAP_TICKS, 5, release lasting this many ticks commits the letter.
- MAX_SYMBOLS, 5, maximum symbols per letter; fixes the code width.
- CNT_W, 4, width of the press and gap tick counters; must hold max(DASH_TICKS, GAP_TICKS).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- HundredmsTimeOut  input  1  one-cycle tick every 100 ms.
- key  input  1  debounced Morse key level, 1 = pressed.
- code  output  MAX_SYMBOLS  last committed letter; bit i = symbol i (first symbol in bit 0); 1 = dash, 0 = dot; unused bits 0.
- code_len  output  3  number of valid symbols in `code`, 1..MAX_SYMBOLS.
- letter_valid  output  1  one-cycle pulse when `code`/`code_len` update.
- overflow  output  1  one-cycle pulse when a symbol beyond MAX_SYMBOLS is entered.
- busy  output  1  high while a letter is being captured (state PRESS or RELEASE).

Behaviour:
- Reset, synchronous, active-high, overrides everything including mid-letter:
  - state = IDLE, counters = 0, internal buffer/length = 0.
  - `code` = 0, `code_len` = 0, `letter_valid` = 0, `overflow` = 0, `busy` = 0.
  - No `letter_valid` is produced for a partially captured letter.
- All outputs are registered.
- States are IDLE, PRESS, RELEASE, COMMIT.
- IDLE:
  - `key` = 1 moves to PRESS with press_cnt = 0.
  - Ticks are ignored.
- PRESS:
  - Each tick increments press_cnt, saturating at DASH_TICKS.
  - On `key` = 0 the press is classified using press_cnt, including a tick arriving in that same cycle.
  - A press of 0 ticks is a dot.
  - If buf_len < MAX_SYMBOLS: write the symbol bit at index buf_len, buf_len += 1, gap_cnt = 0, go to RELEASE.
  - If buf_len == MAX_SYMBOLS: pulse `overflow` for one cycle, clear buffer and buf_len, go to IDLE; no `letter_valid`.
- RELEASE:
  - Each tick increments gap_cnt.
  - When gap_cnt would reach GAP_TICKS, go to COMMIT.
  - `key` = 1 returns to PRESS with press_cnt = 0 and gap_cnt = 0.
  - `key` = 1 takes priority over a gap-completing tick in the same cycle.
- COMMIT, exactly one cycle:
  - Next-cycle outputs: `code` <= buffer, `code_len` <= buf_len, `letter_valid` = 1.
  - Buffer and buf_len are cleared; go to IDLE.
  - `key` is not sampled in COMMIT; a held key is picked up from IDLE on the following cycle.
- Latencies:
  - `letter_valid` rises 2 cycles after the tick that completes the gap.
  - `code`/`code_len` are stable from that cycle until the next commit or reset.
- Tick counting is edge-free: ticks are counted only while in PRESS or RELEASE. The tick phase relative to the key is not aligned, so durations have ±1-tick quantisation.
- `busy` = 1 in PRESS and RELEASE, 0 in IDLE and COMMIT.

Test Plan:
- Reset, then idle 20 ticks -> `code` = 0, `code_len` = 0, no `letter_valid`, `busy` = 0.
- Letter A: press 1 tick, release 1 tick, press 4 ticks, release 6 ticks -> single `letter_valid` pulse with `code` = 5'b00010, `code_len` = 2.
- Boundary: press exactly 2 ticks gives a dot, exactly 3 ticks gives a dash.
- Gap boundary: release of 4 ticks followed by a press continues the same letter; release of 5 ticks commits.
- Same-cycle priority: `key` rises in the same cycle as the 5th gap tick -> letter continues, no commit.
- Overflow: six dots with 1-tick gaps -> `overflow` pulses once on the 6th release, no `letter_valid`, `busy` = 0. A following letter T (one 3-tick press, then 5-tick gap) commits `code` = 1, `code_len` = 1.
- Mid-operation reset: assert `rst` during RELEASE after 3 symbols -> outputs 0 next cycle. A later 1-tick press plus gap gives `code_len` = 1, with no stale symbols.
